// File: rtl/count_pkg.sv
// count_pkg: shared state type and count limits for the BCD count sequencer
package count_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] MAX_COUNT = 16'd9999;
    localparam logic [CNT_W-1:0] MIN_COUNT = 16'd0;
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] v);
        return (v > MAX_COUNT) ? MAX_COUNT : v;
    endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk_50MHz down to one tick every TICK_DIV enabled cycles
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    logic [W-1:0] r_cnt;
    assign tick = en && (r_cnt == W'(TICK_DIV - 1));
    // count only while enabled, wrap on the tick, hold otherwise
    always_ff @(posedge clk_50MHz) begin
        if (reset || clr) r_cnt <= '0;
        else if (en) r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: turns start/stop/load/clear pulses into timed step/load/clear strobes,
// detects terminal count and times the buzzer. AUTO_RELOAD_EN makes terminal count
// reload and keep running instead of entering ALARM.
module count_sequencer
    import count_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int BUZZ_TICKS = 3
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             start_p,
    input  logic             stop_p,
    input  logic             load_p,
    input  logic             clear_p,
    input  logic             updown,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] count_in,
    output logic             step_en,
    output logic             step_up,
    output logic             ld_en,
    output logic [CNT_W-1:0] ld_val,
    output logic             clr_en,
    output logic             running,
    output logic             tc,
    output logic             buzzer
);
    localparam int BW = $clog2(BUZZ_TICKS) + 1;
    state_t r_state, w_next;
    logic [BW-1:0] r_buzz_cnt, w_buzz_cnt;
    logic r_buzz_on, w_buzz_on;
    logic r_step_en, r_step_up, r_ld_en, r_clr_en, r_running, r_tc;
    logic [CNT_W-1:0] r_ld_val, w_ld_val;
    logic w_go, w_en, w_tick, w_term, w_pre_clr, w_buzz_last, w_run_tick, w_tc, w_step, w_ld;

    // a start only wins when no higher-priority command shares its cycle
    assign w_go        = start_p & ~stop_p & ~load_p & ~clear_p;
    // the prescaler also advances in the cycle a start is accepted, so the first step lands TICK_DIV cycles later
    assign w_en        = (r_state == RUN || r_state == ALARM) ? ~clear_p & ~stop_p : w_go;
    assign w_pre_clr   = clear_p | (r_state == ALARM & stop_p);
    assign w_term      = updown ? (sat_count(count_in) == MAX_COUNT) : (count_in == MIN_COUNT);
    assign w_buzz_last = r_buzz_cnt == BW'(BUZZ_TICKS - 1);
    // a tick outside ALARM can only come from RUN or a resume from PAUSE with a fully wound prescaler
    assign w_run_tick  = w_tick & (r_state != ALARM);
    assign w_tc        = w_run_tick & w_term;
    assign w_step      = w_run_tick & ~w_term;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
        .clk_50MHz(clk_50MHz),
        .reset(reset),
        .clr(w_pre_clr),
        .en(w_en),
        .tick(w_tick)
    );

    // state register
    always_ff @(posedge clk_50MHz) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // next state: clear overrides everything, then per-state command handling
    always_comb begin
        w_next = r_state;
        if (clear_p) w_next = IDLE;
        else begin
            case (r_state)
                IDLE:    w_next = w_go ? RUN : IDLE;
                PAUSE:   w_next = w_go ? RUN : PAUSE;
                RUN:     w_next = stop_p ? PAUSE : RUN;
                ALARM:   w_next = (stop_p || (w_tick && w_buzz_last)) ? IDLE : ALARM;
                default: w_next = IDLE;
            endcase
`ifdef AUTO_RELOAD_EN
`else
            if (w_tc) w_next = ALARM;
`endif
        end
    end

    // strobe and buzzer decisions for the coming cycle
    always_comb begin
        w_buzz_on  = r_buzz_on;
        w_buzz_cnt = r_buzz_cnt;
`ifdef AUTO_RELOAD_EN
        w_ld     = (~clear_p & load_p & (r_state == IDLE || r_state == PAUSE)) | w_tc;
        w_ld_val = w_tc ? (updown ? MIN_COUNT : MAX_COUNT) : sat_count(load_val);
`else
        w_ld     = ~clear_p & load_p & (r_state == IDLE || r_state == PAUSE);
        w_ld_val = sat_count(load_val);
`endif
        if (w_tick && r_buzz_on) begin
            w_buzz_on  = ~w_buzz_last;
            w_buzz_cnt = r_buzz_cnt + 1'b1;
        end
        if (w_tc) begin
            w_buzz_on  = 1'b1;
            w_buzz_cnt = '0;
        end
        if (clear_p || (r_state == ALARM && stop_p)) w_buzz_on = 1'b0;
    end

    // register every output so the datapath sees clean one-cycle strobes
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_step_en  <= 1'b0;
            r_step_up  <= 1'b0;
            r_ld_en    <= 1'b0;
            r_ld_val   <= '0;
            r_clr_en   <= 1'b0;
            r_running  <= 1'b0;
            r_tc       <= 1'b0;
            r_buzz_on  <= 1'b0;
            r_buzz_cnt <= '0;
        end else begin
            r_step_en  <= w_step;
            if (w_step) r_step_up <= updown;
            r_ld_en    <= w_ld;
            if (w_ld) r_ld_val <= w_ld_val;
            r_clr_en   <= clear_p;
            r_running  <= w_next == RUN;
            r_tc       <= w_tc;
            r_buzz_on  <= w_buzz_on;
            r_buzz_cnt <= w_buzz_cnt;
        end
    end

    assign step_en = r_step_en;
    assign step_up = r_step_up;
    assign ld_en   = r_ld_en;
    assign ld_val  = r_ld_val;
    assign clr_en  = r_clr_en;
    assign running = r_running;
    assign tc      = r_tc;
    assign buzzer  = r_buzz_on;
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed plus random stimulus against a cycle-level behavioural model
module tb_count_sequencer;
    localparam int TD = 4;
    localparam int BT = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

    logic clk = 1'b0;
    logic reset = 1'b1, start_p = 1'b0, stop_p = 1'b0, load_p = 1'b0, clear_p = 1'b0, updown = 1'b1;
    logic [15:0] load_val = 16'd0, count_in = 16'd5;
    logic step_en, step_up, ld_en, clr_en, running, tc, buzzer;
    logic [15:0] ld_val;

    int n_chk = 0, n_bad = 0, cyc = 0;
    int m_mode = M_IDLE, m_phase = 0, m_left = 0;
    bit m_rst, e_step, e_up, e_ld, e_clr, e_tc;
    logic [15:0] e_ldv;

    always #5 clk = ~clk;

    count_sequencer #(.TICK_DIV(TD), .BUZZ_TICKS(BT)) dut (
        .clk_50MHz(clk), .reset(reset), .start_p(start_p), .stop_p(stop_p),
        .load_p(load_p), .clear_p(clear_p), .updown(updown), .load_val(load_val),
        .count_in(count_in), .step_en(step_en), .step_up(step_up), .ld_en(ld_en),
        .ld_val(ld_val), .clr_en(clr_en), .running(running), .tc(tc), .buzzer(buzzer)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // behavioural model: counts active cycles toward each tick and remaining buzz ticks
    task automatic model();
        bit go, act, tick, term;
        {e_step, e_ld, e_clr, e_tc, m_rst} = '0;
        if (reset) begin
            m_rst = 1; m_mode = M_IDLE; m_phase = 0; m_left = 0;
            return;
        end
        if (clear_p) begin
            e_clr = 1; m_mode = M_IDLE; m_phase = 0; m_left = 0;
            return;
        end
        term = updown ? (count_in >= 16'd9999) : (count_in == 16'd0);
        go   = start_p && !stop_p && !load_p;
        act  = (m_mode == M_RUN || m_mode == M_ALARM) ? !stop_p : go;
        tick = 0;
        if (act) begin
            m_phase++;
            if (m_phase == TD) begin m_phase = 0; tick = 1; end
        end
        case (m_mode)
            M_IDLE, M_PAUSE: begin
                if (load_p) begin e_ld = 1; e_ldv = (load_val > 16'd9999) ? 16'd9999 : load_val; end
                else if (go) m_mode = M_RUN;
            end
            M_RUN: if (stop_p) m_mode = M_PAUSE;
            default: begin
                if (stop_p) begin m_mode = M_IDLE; m_phase = 0; m_left = 0; end
                else if (tick) begin m_left--; if (m_left == 0) m_mode = M_IDLE; end
            end
        endcase
        if (tick && m_mode == M_RUN) begin
            if (term) begin
                e_tc = 1;
                m_left = BT;
`ifdef AUTO_RELOAD_EN
                e_ld = 1; e_ldv = updown ? 16'd0 : 16'd9999;
`else
                m_mode = M_ALARM;
`endif
            end else begin
                e_step = 1; e_up = updown;
`ifdef AUTO_RELOAD_EN
                if (m_left > 0) m_left--;
`endif
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model();
        #1;
        cyc++;
        chk("step_en", step_en, e_step);
        chk("ld_en", ld_en, e_ld);
        chk("clr_en", clr_en, e_clr);
        chk("tc", tc, e_tc);
        chk("running", running, m_mode == M_RUN);
        chk("buzzer", buzzer, m_left > 0);
        if (e_step) chk("step_up", step_up, e_up);
        if (e_ld) chk("ld_val", ld_val, e_ldv);
        if (m_rst) begin
            chk("rst_step_up", step_up, 0);
            chk("rst_ld_val", ld_val, 0);
        end
    endtask

    task automatic drive(input bit s, input bit p, input bit l, input bit c);
        start_p = s; stop_p = p; load_p = l; clear_p = c;
        cycle();
        {start_p, stop_p, load_p, clear_p} = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_step(input int budget);
        int k;
        k = 0;
        while (!e_step && k < budget) begin cycle(); k++; end
        if (!e_step) chk("wait_step_timeout", 0, 1);
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        idle(6);
        drive(1, 0, 0, 0);
        idle(13);
        wait_step(8);
        idle(1);
        drive(0, 1, 0, 0);
        idle(20);
        drive(1, 0, 0, 0);
        idle(6);
        count_in = 16'd9999;
        idle(14);
        count_in = 16'd5;
        load_val = 16'd12345;
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        idle(2);
        drive(0, 0, 1, 0);
        count_in = 16'd9999;
        idle(6);
        drive(1, 0, 0, 1);
        idle(3);
        updown = 1'b0;
        count_in = 16'd0;
        drive(1, 0, 0, 0);
        idle(12);
        drive(0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(499) == 0);
            start_p  = ($urandom_range(5) == 0);
            stop_p   = ($urandom_range(15) == 0);
            load_p   = ($urandom_range(15) == 0);
            clear_p  = ($urandom_range(59) == 0);
            updown   = $urandom_range(1) == 1;
            load_val = 16'($urandom_range(16'hffff));
            case ($urandom_range(3))
                0: count_in = 16'd0;
                1: count_in = 16'd9999;
                2: count_in = 16'($urandom_range(16'hffff, 10000));
                default: count_in = 16'($urandom_range(9998, 1));
            endcase
            cycle();
            {reset, start_p, stop_p, load_p, clear_p} = '0;
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
